mips_multicycle_exec: RTL and testbench
=======================================

Name: mips_multicycle_exec

Overview:
Multicycle MIPS execution block that fuses three parts: the control-path opcode decoder, the ALU-control funct decoder, and the datapath. The datapath holds a 32x32 register file, a word-addressed data memory, the ALU and a sign-extender. An external sequencer presents one instruction word at a time and pulses newinstr; the block runs that instruction through ID, EX, MEM and WB. There is no PC and no fetch, and branches are decoded but never taken.

Parameters:
MEM_WORDS, 128, number of 32-bit data-memory words (power of two; index width MA = log2(MEM_WORDS)).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
instrword  in  32  instruction word, captured when newinstr is sampled high
newinstr  in  1  start strobe, sampled synchronously
done  out  1  high for exactly the WB cycle
busy  out  1  high in ID, EX, MEM and WB
alu_result  out  32  registered ALU result of the current or last instruction
alu_zero  out  1  alu_result == 0
dbg_reg_addr  in  5  combinational register-file read address
dbg_reg_data  out  32  regfile[dbg_reg_addr]; always 0 when the address is 0
dbg_mem_addr  in  MA  combinational memory read address
dbg_mem_data  out  32  mem[dbg_mem_addr]

Behaviour:
- Reset (async, active-high):
  - Regfile and memory cleared to 0.
  - State = IDLE; IR, latched controls, alu_result and load-data register = 0.
  - done = 0, busy = 0.
- FSM states: IDLE, ID, EX, MEM, WB.
  - newinstr = 1 at an edge, in any state: IR <= instrword, state <= ID. This has priority and aborts the instruction in flight. A write that would have occurred at that same edge is suppressed.
  - Otherwise ID->EX->MEM->WB->IDLE, one edge each. IDLE holds.
- Decode (combinational from IR; opcode = IR[31:26]):
  - 0x00 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 0x23 lw: ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUOp=00.
  - 0x2B sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 0x08 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x04 beq: Branch=1, ALUOp=01; no architectural effect.
  - Any other opcode: all controls 0 (nop).
- ALU control (4-bit):
  - ALUOp 00 -> 0010 (add); ALUOp 01 -> 0110 (sub).
  - ALUOp 10, by funct: 0x20 add -> 0010; 0x22 sub -> 0110; 0x24 and -> 0000; 0x25 or -> 0001; 0x27 nor -> 1100; 0x2A slt -> 0111.
  - ALUOp 10 with any other funct -> 1111 (result 0).
- ALU: 32-bit, wrap-around add/sub, no overflow trap. slt is a signed compare giving 1 or 0.
- Operands: A = rs. B = rt, or sign-extended IR[15:0] when ALUSrc = 1.
- Cycle timing, with E0 = the edge at which newinstr is sampled:
  - E1: controls latched.
  - E2: alu_result registered.
  - E3: sw writes mem[alu_result[MA+1:2]] <= rt; lw registers mem[alu_result[MA+1:2]]. Address bits [1:0] and above MA+1 are ignored, so addresses wrap modulo the memory size.
  - E4: if RegWrite, the destination is written (rd when RegDst = 1, else rt) with the load data (MemToReg = 1) or alu_result.
- Writes to r0 are discarded.
- Register/memory reads are combinational on current contents.

Decomposition:
- Package mips_pkg holds: opcode and funct constants, ALUCtrl encodings, the FSM state enum, and a control-signal struct.
- One natural sub-module: mips_regfile (32x32, 2 read ports + debug read port, 1 write port, async clear).
- Decode, ALU control and the data memory stay inline.

Test Plan:
- Reset mid-run, then release -> dbg_reg_data = 0 for all 32 addresses; dbg_mem_data = 0 for all words; done = 0; busy = 0.
- addi r1,r0,5 (0x20010005), then addi r2,r0,-3 (0x2002FFFD) -> after E4 of each, r1 = 5 and r2 = 0xFFFFFFFD; done is high only during the WB cycle.
- With r1 = 5 and r2 = -3:
  - add r3,r1,r2 -> r3 = 2.
  - sub r3,r1,r2 -> r3 = 8.
  - slt r4,r2,r1 -> r4 = 1.
  - nor r5,r0,r0 -> r5 = 0xFFFFFFFF.
- sw r1,8(r0) -> mem[2] = 5 after E3. Then lw r6,8(r0) -> r6 = 5. Then sw r1,0x200(r0) -> wraps to mem[0] = 5.
- addi r0,r0,7 -> r0 still reads 0. An unknown opcode 0x3F -> no register or memory change.
- addi r7,r0,9, with newinstr pulsed again during EX carrying addi r8,r0,1 -> r7 stays 0 and r8 = 1 after E4 of the new instruction.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS execution block.
// Holds the opcode and funct constants, the ALU-control encodings, the FSM
// state enum, the control-signal struct, and the pure decode and ALU helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NONE = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [2:0] {ST_IDLE, ST_ID, ST_EX, ST_MEM, ST_WB} state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Main control decoder; unknown opcodes behave as a nop (all controls low).
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = 2'b10; end
      OP_LW: begin
        c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
      end
      OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_BEQ:  begin c.branch = 1'b1; c.alu_op = 2'b01; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic alu_ctrl_e alu_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_ctrl_e c;
    c = ALU_NONE;
    case (alu_op)
      2'b00: c = ALU_ADD;
      2'b01: c = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  c = ALU_ADD;
          FN_SUB:  c = ALU_SUB;
          FN_AND:  c = ALU_AND;
          FN_OR:   c = ALU_OR;
          FN_NOR:  c = ALU_NOR;
          FN_SLT:  c = ALU_SLT;
          default: c = ALU_NONE;
        endcase
      end
      default: c = ALU_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input alu_ctrl_e c, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (c)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one
// write port, asynchronous active-high clear. r0 always reads as zero and
// writes to it are dropped.
//   clock, reset      : clock / async clear
//   ra1/ra2/ra3 -> rd1/rd2/rd3 : combinational reads
//   we, wa, wd        : synchronous write
module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
  assign rd3 = (ra3 == 5'd0) ? '0 : regs_q[ra3];

endmodule

// File: rtl/mips_multicycle_exec.sv
// Multicycle MIPS execution block: opcode decode, ALU control and datapath
// (register file, word-addressed data memory, ALU, sign extender).
// An external sequencer pulses newinstr with instrword; the instruction then
// walks ID -> EX -> MEM -> WB. No PC, no fetch, branches never taken.
//   clock, reset        : clock / async active-high clear
//   instrword, newinstr : instruction and start strobe (aborts any in flight)
//   done, busy          : WB-cycle flag / any non-idle state
//   alu_result, alu_zero: registered ALU result and its zero flag
//   dbg_reg_*, dbg_mem_*: combinational debug reads
module mips_multicycle_exec
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 128,
  localparam int MA = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   instrword,
  input  logic          newinstr,
  output logic          done,
  output logic          busy,
  output logic [31:0]   alu_result,
  output logic          alu_zero,
  input  logic [4:0]    dbg_reg_addr,
  output logic [31:0]   dbg_reg_data,
  input  logic [MA-1:0] dbg_mem_addr,
  output logic [31:0]   dbg_mem_data
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] ldata_q, ldata_d;
  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0]   rs_data, rt_data, imm_sext, alu_b;
  logic [MA-1:0] mem_idx;
  logic          mem_we, rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;

  // Branch is decoded and latched but nothing consumes it.
  logic unused_branch;
  assign unused_branch = ctrl_q.branch;

  mips_regfile u_regfile (
    .clock (clock),
    .reset (reset),
    .ra1   (ir_q[25:21]),
    .ra2   (ir_q[20:16]),
    .ra3   (dbg_reg_addr),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .rd3   (dbg_reg_data),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_b    = ctrl_q.alu_src ? imm_sext : rt_data;
  // Byte address -> word index; low two bits and high bits drop, so it wraps.
  assign mem_idx  = alu_q[MA+1:2];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    ldata_d = ldata_q;
    if (newinstr) begin
      ir_d    = instrword;
      state_d = ST_ID;
    end else begin
      case (state_q)
        ST_ID: begin
          ctrl_d  = decode(ir_q[31:26]);
          state_d = ST_EX;
        end
        ST_EX: begin
          alu_d   = alu(alu_ctrl(ctrl_q.alu_op, ir_q[5:0]), rs_data, alu_b);
          state_d = ST_MEM;
        end
        ST_MEM: begin
          if (ctrl_q.mem_read) ldata_d = mem_q[mem_idx];
          state_d = ST_WB;
        end
        ST_WB:   state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A strobe at the same edge as a write cancels the write.
  assign mem_we = (state_q == ST_MEM) && ctrl_q.mem_write && !newinstr;
  assign rf_we  = (state_q == ST_WB) && ctrl_q.reg_write && !newinstr;
  assign rf_wa  = ctrl_q.reg_dst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd  = ctrl_q.mem_to_reg ? ldata_q : alu_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      ldata_q <= ldata_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_idx] <= rt_data;
    end
  end

  assign dbg_mem_data = mem_q[dbg_mem_addr];
  assign alu_result   = alu_q;
  assign alu_zero     = (alu_q == 32'd0);
  assign done         = (state_q == ST_WB);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_multicycle_exec.sv
module tb_mips_multicycle_exec;
  localparam int MEM_WORDS = 128;
  localparam int MA = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instrword = '0;
  logic          newinstr = 1'b0;
  logic          done, busy, alu_zero;
  logic [31:0]   alu_result, dbg_reg_data, dbg_mem_data;
  logic [4:0]    dbg_reg_addr = '0;
  logic [MA-1:0] dbg_mem_addr = '0;

  always #5 clock = ~clock;

  mips_multicycle_exec #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock        (clock),
    .reset        (reset),
    .instrword    (instrword),
    .newinstr     (newinstr),
    .done         (done),
    .busy         (busy),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem_data (dbg_mem_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural reference state.
  logic [31:0] mreg [32];
  logic [31:0] mmem [MEM_WORDS];
  logic [31:0] exp_alu = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < MEM_WORDS; i++) mmem[i] = '0;
    exp_alu = '0;
  endtask

  // Architectural effect of one instruction. abort_k = 0: runs to completion;
  // 1..4: a new strobe lands on edge E<abort_k>, cancelling that edge's write
  // and everything after it.
  task automatic model_exec(input logic [31:0] w, input int abort_k);
    logic [5:0]  op, fn;
    int          rs, rt, rd, dst;
    logic [31:0] a, b, imm, res, wdata;
    int unsigned idx;
    bit          wr, st;
    op = w[31:26]; fn = w[5:0];
    rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    a = mreg[rs]; b = mreg[rt];
    imm = {{16{w[15]}}, w[15:0]};
    wr = 0; st = 0; dst = 0; res = '0;
    case (op)
      6'h00: begin
        wr = 1; dst = rd;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: res = '0;
        endcase
      end
      6'h23: begin wr = 1; dst = rt; res = a + imm; end
      6'h2B: begin st = 1; res = a + imm; end
      6'h08: begin wr = 1; dst = rt; res = a + imm; end
      6'h04: res = a - b;
      default: res = a + b;
    endcase
    idx = (res >> 2) % 32'(MEM_WORDS);
    wdata = (op == 6'h23) ? mmem[idx] : res;
    if (st && (abort_k == 0 || abort_k == 4)) mmem[idx] = b;
    if (abort_k == 0) begin
      if (wr && dst != 0) mreg[dst] = wdata;
      exp_alu = res;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic issue(input logic [31:0] w);
    instrword = w;
    newinstr  = 1'b1;
    @(negedge clock);
    newinstr  = 1'b0;
  endtask

  // Called right after issue(); follows the instruction to IDLE.
  task automatic complete(input string tag);
    chk({tag, " busy@ID"}, 32'(busy), 32'd1);
    chk({tag, " done@ID"}, 32'(done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk({tag, " done@MEM"}, 32'(done), 32'd0);
    @(negedge clock);
    chk({tag, " done@WB"}, 32'(done), 32'd1);
    chk({tag, " busy@WB"}, 32'(busy), 32'd1);
    @(negedge clock);
    chk({tag, " done@IDLE"}, 32'(done), 32'd0);
    chk({tag, " busy@IDLE"}, 32'(busy), 32'd0);
    chk({tag, " alu_result"}, alu_result, exp_alu);
    chk({tag, " alu_zero"}, 32'(alu_zero), 32'(exp_alu == 32'd0));
  endtask

  task automatic run(input string tag, input logic [31:0] w);
    issue(w);
    model_exec(w, 0);
    complete(tag);
  endtask

  task automatic chk_reg(input string tag, input int a, input logic [31:0] exp);
    dbg_reg_addr = 5'(a);
    #1;
    chk(tag, dbg_reg_data, exp);
    @(negedge clock);
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [31:0] exp);
    dbg_mem_addr = MA'(a);
    #1;
    chk(tag, dbg_mem_data, exp);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_reg_addr = 5'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), dbg_reg_data, mreg[i]);
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      dbg_mem_addr = MA'(i);
      #1;
      chk($sformatf("%s mem%0d", tag, i), dbg_mem_data, mmem[i]);
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [7];
    logic [5:0] ops [3];
    int rs, rt, rd;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3B};
    ops = '{6'h3F, 6'h0D, 6'h02};
    rs = int'($urandom_range(0, 7)); rt = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: return rtype(rs, rt, rd, fns[$urandom_range(0, 6)]);
      1: return itype(6'h23, rs, rt, 16'($urandom));
      2: return itype(6'h2B, rs, rt, 16'($urandom));
      3: return itype(6'h08, rs, rt, 16'($urandom));
      4: return itype(6'h04, rs, rt, 16'($urandom));
      default: return itype(ops[$urandom_range(0, 2)], rs, rt, 16'($urandom));
    endcase
  endfunction

  initial begin
    logic [31:0] wa, wb;
    int k;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset alu", alu_result, 32'd0);

    // Put some state in, then reset in the middle of an instruction.
    run("pre addi", 32'h20010005);
    run("pre sw", itype(6'h2B, 0, 1, 16'h0008));
    issue(itype(6'h08, 0, 9, 16'h0003));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    chk("postrst done", 32'(done), 32'd0);
    chk("postrst busy", 32'(busy), 32'd0);
    check_all("postrst");

    run("addi r1", 32'h20010005);
    chk_reg("r1=5", 1, 32'd5);
    run("addi r2", 32'h2002FFFD);
    chk_reg("r2=-3", 2, 32'hFFFFFFFD);
    run("add r3", rtype(1, 2, 3, 6'h20));
    chk_reg("add r3", 3, 32'd2);
    run("sub r3", rtype(1, 2, 3, 6'h22));
    chk_reg("sub r3", 3, 32'd8);
    run("slt r4", rtype(2, 1, 4, 6'h2A));
    chk_reg("slt r4", 4, 32'd1);
    run("nor r5", rtype(0, 0, 5, 6'h27));
    chk_reg("nor r5", 5, 32'hFFFFFFFF);
    run("sw 8", itype(6'h2B, 0, 1, 16'h0008));
    chk_mem("sw mem2", 2, 32'd5);
    run("lw r6", itype(6'h23, 0, 6, 16'h0008));
    chk_reg("lw r6", 6, 32'd5);
    run("sw wrap", itype(6'h2B, 0, 1, 16'h0200));
    chk_mem("wrap mem0", 0, 32'd5);
    run("addi r0", itype(6'h08, 0, 0, 16'h0007));
    chk_reg("r0 zero", 0, 32'd0);
    run("op3f", itype(6'h3F, 1, 2, 16'h1234));
    check_all("op3f");

    // Abort during EX: the strobe lands on E2.
    wa = itype(6'h08, 0, 7, 16'h0009);
    wb = itype(6'h08, 0, 8, 16'h0001);
    issue(wa);
    @(negedge clock);
    model_exec(wa, 2);
    issue(wb);
    model_exec(wb, 0);
    complete("abort new");
    chk_reg("abort r7", 7, 32'd0);
    chk_reg("abort r8", 8, 32'd1);
    check_all("abort");

    // Random instructions, some cut short at a random edge E1..E4.
    for (int n = 0; n < 60; n++) begin
      wa = rand_instr();
      if ($urandom_range(0, 4) == 0) begin
        k = int'($urandom_range(1, 4));
        wb = rand_instr();
        issue(wa);
        repeat (k - 1) @(negedge clock);
        model_exec(wa, k);
        issue(wb);
        model_exec(wb, 0);
        complete($sformatf("rnd%0d abort%0d", n, k));
      end else begin
        run($sformatf("rnd%0d", n), wa);
      end
      check_all($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
